// File: rtl/tag_match_unit.sv
// N-way tag compare stage: registered hit vector / encoded way / victim,
// per-set tree pseudo-LRU state and saturating hit/miss counters.
module tag_match_unit #(
    parameter  int TAG_W = 9,
    parameter  int WAYS  = 2,
    parameter  int SETS  = 8,
    parameter  int CNT_W = 16,
    localparam int SET_W = $clog2(SETS),
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [TAG_W-1:0]      req_tag,
    input  logic [SET_W-1:0]      req_set,
    input  logic [WAYS*TAG_W-1:0] way_tags,
    input  logic [WAYS-1:0]       way_valid,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_hit,
    output logic [WAYS-1:0]       resp_hit_vec,
    output logic [WAY_W-1:0]      resp_way,
    output logic                  resp_multi,
    output logic [WAY_W-1:0]      resp_victim,
    input  logic                  fill_valid,
    input  logic [SET_W-1:0]      fill_set,
    input  logic [WAY_W-1:0]      fill_way,
    input  logic                  stats_clear,
    output logic [CNT_W-1:0]      hit_count,
    output logic [CNT_W-1:0]      miss_count
);

    if (WAYS != 2 && WAYS != 4) begin : g_bad_ways
        $error("tag_match_unit: WAYS must be 2 or 4");
    end

    // PLRU state is kept as 3 bits per set; with 2 ways only bit 0 is used.
    function automatic logic [1:0] plru_victim(input logic [2:0] b);
        if (WAYS == 2) return {1'b0, b[0]};
        if (b[0]) return b[2] ? 2'd3 : 2'd2;
        return b[1] ? 2'd1 : 2'd0;
    endfunction

    function automatic logic [2:0] plru_touch(input logic [2:0] b, input logic [1:0] w);
        logic [2:0] r;
        r = b;
        if (WAYS == 2) begin
            r[0] = ~w[0];
        end else begin
            r[0] = ~w[1];
            if (w[1]) r[2] = ~w[0];
            else      r[1] = ~w[0];
        end
        return r;
    endfunction

    logic                 resp_valid_reg;
    logic                 resp_hit_reg;
    logic [WAYS-1:0]      resp_hit_vec_reg;
    logic [WAY_W-1:0]     resp_way_reg;
    logic                 resp_multi_reg;
    logic [WAY_W-1:0]     resp_victim_reg;
    logic [CNT_W-1:0]     hit_count_reg;
    logic [CNT_W-1:0]     miss_count_reg;

    logic [WAYS-1:0]      match_vec;
    logic                 match_any;
    logic                 match_multi;
    logic [WAY_W-1:0]     match_way;
    logic                 inval_found;
    logic [WAY_W-1:0]     inval_way;
    logic [WAY_W-1:0]     victim_next;
    logic                 accept;
    logic                 hit_touch;
    logic [2:0]           plru_cur [SETS];

    assign req_ready = !resp_valid_reg || resp_ready;
    assign accept    = req_valid && req_ready;

    genvar gi;
    for (gi = 0; gi < WAYS; gi++) begin : g_match
        assign match_vec[gi] = way_valid[gi] && (way_tags[gi*TAG_W +: TAG_W] == req_tag);
    end

    // Scanning from the top down leaves the lowest qualifying index.
    always_comb begin
        match_way   = '0;
        inval_found = 1'b0;
        inval_way   = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (match_vec[i]) match_way = WAY_W'(i);
            if (!way_valid[i]) begin
                inval_found = 1'b1;
                inval_way   = WAY_W'(i);
            end
        end
        match_any   = |match_vec;
        match_multi = ($countones(match_vec) > 1);
        victim_next = inval_found ? inval_way : WAY_W'(plru_victim(plru_cur[req_set]));
    end

    assign hit_touch = accept && match_any;

    // A fill to the same set as an accepted hit wins and uses the old state.
    for (gi = 0; gi < SETS; gi++) begin : g_plru
        logic [2:0] bits_reg;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                bits_reg <= '0;
            end else if (fill_valid && fill_set == SET_W'(gi)) begin
                bits_reg <= plru_touch(bits_reg, 2'(fill_way));
            end else if (hit_touch && req_set == SET_W'(gi)) begin
                bits_reg <= plru_touch(bits_reg, 2'(match_way));
            end
        end
        assign plru_cur[gi] = bits_reg;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_valid_reg   <= 1'b0;
            resp_hit_reg     <= 1'b0;
            resp_hit_vec_reg <= '0;
            resp_way_reg     <= '0;
            resp_multi_reg   <= 1'b0;
            resp_victim_reg  <= '0;
        end else if (accept) begin
            resp_valid_reg   <= 1'b1;
            resp_hit_reg     <= match_any;
            resp_hit_vec_reg <= match_vec;
            resp_way_reg     <= match_way;
            resp_multi_reg   <= match_multi;
            resp_victim_reg  <= victim_next;
        end else if (resp_ready) begin
            resp_valid_reg   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else if (stats_clear) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else if (accept) begin
            if (match_any && hit_count_reg != '1)
                hit_count_reg <= hit_count_reg + 1'b1;
            if (!match_any && miss_count_reg != '1)
                miss_count_reg <= miss_count_reg + 1'b1;
        end
    end

    assign resp_valid   = resp_valid_reg;
    assign resp_hit     = resp_hit_reg;
    assign resp_hit_vec = resp_hit_vec_reg;
    assign resp_way     = resp_way_reg;
    assign resp_multi   = resp_multi_reg;
    assign resp_victim  = resp_victim_reg;
    assign hit_count    = hit_count_reg;
    assign miss_count   = miss_count_reg;

endmodule

// File: tb/tb_tag_match_unit.sv
// Bench for tag_match_unit (4 ways, 2-bit counters): a reference model feeds a
// result queue on every accept, and each delivered response is compared to its head.
module tb_tag_match_unit;
    localparam int TAG_W = 9;
    localparam int WAYS  = 4;
    localparam int SETS  = 8;
    localparam int CNT_W = 2;
    localparam int SET_W = 3;
    localparam int WAY_W = 2;
    localparam logic [CNT_W-1:0] MAXC = {CNT_W{1'b1}};

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  req_valid;
    logic                  req_ready;
    logic [TAG_W-1:0]      req_tag;
    logic [SET_W-1:0]      req_set;
    logic [WAYS*TAG_W-1:0] way_tags;
    logic [WAYS-1:0]       way_valid;
    logic                  resp_valid;
    logic                  resp_ready;
    logic                  resp_hit;
    logic [WAYS-1:0]       resp_hit_vec;
    logic [WAY_W-1:0]      resp_way;
    logic                  resp_multi;
    logic [WAY_W-1:0]      resp_victim;
    logic                  fill_valid;
    logic [SET_W-1:0]      fill_set;
    logic [WAY_W-1:0]      fill_way;
    logic                  stats_clear;
    logic [CNT_W-1:0]      hit_count;
    logic [CNT_W-1:0]      miss_count;

    always #5 clk = ~clk;

    tag_match_unit #(.TAG_W(TAG_W), .WAYS(WAYS), .SETS(SETS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag), .req_set(req_set),
        .way_tags(way_tags), .way_valid(way_valid),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
        .resp_hit_vec(resp_hit_vec), .resp_way(resp_way), .resp_multi(resp_multi),
        .resp_victim(resp_victim),
        .fill_valid(fill_valid), .fill_set(fill_set), .fill_way(fill_way),
        .stats_clear(stats_clear), .hit_count(hit_count), .miss_count(miss_count)
    );

    typedef struct packed {
        logic            hit;
        logic [WAYS-1:0] vec;
        logic [1:0]      way;
        logic            multi;
        logic [1:0]      victim;
    } exp_t;

    exp_t             sb_q[$];
    logic             m_valid;
    logic [2:0]       m_plru [SETS];
    logic [CNT_W-1:0] m_hits;
    logic [CNT_W-1:0] m_miss;
    int               n_cmp = 0;
    int               n_bad = 0;

    function automatic logic [1:0] m_victim(input logic [2:0] b);
        if (b[0]) return b[2] ? 2'd3 : 2'd2;
        return b[1] ? 2'd1 : 2'd0;
    endfunction

    function automatic logic [2:0] m_touch(input logic [2:0] b, input logic [1:0] w);
        logic [2:0] r;
        r = b;
        r[0] = ~w[1];
        if (w[1]) r[2] = ~w[0];
        else      r[1] = ~w[0];
        return r;
    endfunction

    task automatic set_tags(input logic [8:0] t0, input logic [8:0] t1,
                            input logic [8:0] t2, input logic [8:0] t3, input logic [3:0] v);
        way_tags  = {t3, t2, t1, t0};
        way_valid = v;
    endtask

    // One clock: model update from the inputs already driven, then scoreboard check.
    task automatic step();
        logic acc;
        exp_t e;
        int   nvalid;
        #1;
        if (rst_n) begin
            n_cmp++;
            if (req_ready !== (!m_valid || resp_ready)) begin
                n_bad++;
                $display("FAIL req_ready: got %b expected %b", req_ready, (!m_valid || resp_ready));
            end
        end
        acc = rst_n && req_valid && (!m_valid || resp_ready);
        if (!rst_n) begin
            sb_q.delete();
            m_valid = 1'b0;
            m_hits  = '0;
            m_miss  = '0;
            for (int s = 0; s < SETS; s++) m_plru[s] = 3'b000;
        end else begin
            if (m_valid && resp_ready && sb_q.size() > 0) void'(sb_q.pop_front());
            e = '0;
            nvalid = 0;
            e.victim = m_victim(m_plru[req_set]);
            for (int i = 0; i < WAYS; i++)
                e.vec[i] = way_valid[i] && (way_tags[i*TAG_W +: TAG_W] == req_tag);
            for (int i = WAYS - 1; i >= 0; i--) begin
                if (e.vec[i]) e.way = 2'(i);
                if (!way_valid[i]) begin
                    e.victim = 2'(i);
                    nvalid++;
                end
            end
            e.hit   = |e.vec;
            e.multi = ($countones(e.vec) > 1);
            if (acc) sb_q.push_back(e);
            if (acc && e.hit && !(fill_valid && fill_set == req_set))
                m_plru[req_set] = m_touch(m_plru[req_set], e.way);
            if (fill_valid) m_plru[fill_set] = m_touch(m_plru[fill_set], fill_way);
            if (stats_clear) begin
                m_hits = '0;
                m_miss = '0;
            end else if (acc) begin
                if (e.hit && m_hits != MAXC)  m_hits = m_hits + 1'b1;
                if (!e.hit && m_miss != MAXC) m_miss = m_miss + 1'b1;
            end
            m_valid = acc ? 1'b1 : (resp_ready ? 1'b0 : m_valid);
        end
        @(posedge clk);
        #1;
        n_cmp += 3;
        if (resp_valid !== m_valid) begin
            n_bad++;
            $display("FAIL resp_valid: got %b expected %b", resp_valid, m_valid);
        end
        if (hit_count !== m_hits) begin
            n_bad++;
            $display("FAIL hit_count: got %0d expected %0d", hit_count, m_hits);
        end
        if (miss_count !== m_miss) begin
            n_bad++;
            $display("FAIL miss_count: got %0d expected %0d", miss_count, m_miss);
        end
        if (m_valid) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_empty: got empty queue expected one entry");
            end else if ({resp_hit, resp_hit_vec, resp_way, resp_multi, resp_victim} !== sb_q[0]) begin
                n_bad++;
                $display("FAIL resp_fields: got hit=%b vec=%b way=%0d multi=%b victim=%0d expected hit=%b vec=%b way=%0d multi=%b victim=%0d",
                         resp_hit, resp_hit_vec, resp_way, resp_multi, resp_victim,
                         sb_q[0].hit, sb_q[0].vec, sb_q[0].way, sb_q[0].multi, sb_q[0].victim);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_valid   = 1'b0;
        resp_ready  = 1'b1;
        fill_valid  = 1'b0;
        stats_clear = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        req_tag = '0; req_set = '0; fill_set = '0; fill_way = '0;
        set_tags(9'h0, 9'h0, 9'h0, 9'h0, 4'b0000);
        @(negedge clk);
        step();
        step();
        n_cmp++;
        if ({resp_valid, resp_hit, resp_hit_vec, resp_way, resp_multi, resp_victim} !== '0) begin
            n_bad++;
            $display("FAIL reset_resp: got %b expected all zero",
                     {resp_valid, resp_hit, resp_hit_vec, resp_way, resp_multi, resp_victim});
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_req_ready: got %b expected 1", req_ready);
        end
        #1;
        @(negedge clk);
    endtask

    task automatic test_basic_hit();
        set_tags(9'h10, 9'h20, 9'h30, 9'h40, 4'b1111);
        req_valid = 1'b1; req_tag = 9'h30; req_set = 3'd2;
        step();
        req_valid = 1'b0;
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_hit !== 1'b1 || resp_hit_vec !== 4'b0100 ||
            resp_way !== 2'd2 || resp_multi !== 1'b0 || resp_victim !== 2'd0 || hit_count !== 2'd1) begin
            n_bad++;
            $display("FAIL basic_hit: got v=%b hit=%b vec=%b way=%0d multi=%b victim=%0d hits=%0d expected 1 1 0100 2 0 0 1",
                     resp_valid, resp_hit, resp_hit_vec, resp_way, resp_multi, resp_victim, hit_count);
        end
        step();
    endtask

    task automatic test_victim_sequence();
        logic [1:0] exp_v [5] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd0};
        set_tags(9'h1, 9'h2, 9'h3, 9'h4, 4'b1111);
        for (int k = 0; k < 5; k++) begin
            req_valid = 1'b1; req_tag = 9'h1FF; req_set = 3'd5;
            step();
            req_valid = 1'b0;
            n_cmp++;
            if (resp_victim !== exp_v[k] || resp_hit !== 1'b0) begin
                n_bad++;
                $display("FAIL victim_seq[%0d]: got victim=%0d hit=%b expected victim=%0d hit=0",
                         k, resp_victim, resp_hit, exp_v[k]);
            end
            fill_valid = 1'b1; fill_set = 3'd5; fill_way = exp_v[k];
            step();
            fill_valid = 1'b0;
        end
    endtask

    task automatic test_invalid_and_multi();
        set_tags(9'h1, 9'h2, 9'h3, 9'h4, 4'b1011);
        req_valid = 1'b1; req_tag = 9'h1FF; req_set = 3'd5;
        step();
        n_cmp++;
        if (resp_victim !== 2'd2) begin
            n_bad++;
            $display("FAIL victim_invalid_way: got %0d expected 2", resp_victim);
        end
        set_tags(9'h22, 9'h55, 9'h11, 9'h55, 4'b1111);
        req_tag = 9'h55; req_set = 3'd6;
        step();
        req_valid = 1'b0;
        n_cmp++;
        if (resp_hit_vec !== 4'b1010 || resp_way !== 2'd1 || resp_multi !== 1'b1) begin
            n_bad++;
            $display("FAIL multi_hit: got vec=%b way=%0d multi=%b expected vec=1010 way=1 multi=1",
                     resp_hit_vec, resp_way, resp_multi);
        end
        step();
    endtask

    task automatic test_stall_and_stream();
        set_tags(9'h10, 9'h20, 9'h30, 9'h40, 4'b1111);
        req_valid = 1'b1; req_tag = 9'h20; req_set = 3'd3; resp_ready = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            req_tag = 9'h10 + 9'(k); req_set = 3'(k);
            set_tags(9'h10, 9'h11, 9'h12, 9'h13, 4'b0111);
            step();
            n_cmp++;
            if (req_ready !== 1'b0 || resp_way !== 2'd1) begin
                n_bad++;
                $display("FAIL stall[%0d]: got ready=%b way=%0d expected ready=0 way=1", k, req_ready, resp_way);
            end
        end
        resp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        req_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            set_tags(9'($urandom_range(0, 3)), 9'($urandom_range(0, 3)),
                     9'($urandom_range(0, 3)), 9'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            req_tag    = 9'($urandom_range(0, 3));
            req_set    = 3'($urandom_range(0, 7));
            fill_valid = 1'($urandom_range(0, 1));
            fill_set   = 3'($urandom_range(0, 7));
            fill_way   = 2'($urandom_range(0, 3));
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_same_set();
        do_reset();
        set_tags(9'h10, 9'h20, 9'h30, 9'h40, 4'b1111);
        req_valid = 1'b1; req_tag = 9'h40; req_set = 3'd1;
        fill_valid = 1'b1; fill_set = 3'd1; fill_way = 2'd0;
        step();
        fill_valid = 1'b0;
        req_tag = 9'h1FF;
        step();
        n_cmp++;
        if (resp_victim !== 2'd2) begin
            n_bad++;
            $display("FAIL same_set_b0: got victim %0d expected 2", resp_victim);
        end
        req_valid = 1'b0;
        fill_valid = 1'b1; fill_set = 3'd1; fill_way = 2'd2;
        step();
        fill_valid = 1'b0;
        req_valid = 1'b1;
        step();
        n_cmp++;
        if (resp_victim !== 2'd1) begin
            n_bad++;
            $display("FAIL same_set_b1: got victim %0d expected 1", resp_victim);
        end
        req_valid = 1'b0;
        fill_valid = 1'b1; fill_set = 3'd1; fill_way = 2'd0;
        step();
        req_valid = 1'b1; req_tag = 9'h40; req_set = 3'd1;
        fill_valid = 1'b1; fill_set = 3'd4; fill_way = 2'd0;
        step();
        fill_valid = 1'b0;
        req_tag = 9'h1FF;
        step();
        n_cmp++;
        if (resp_victim !== 2'd1) begin
            n_bad++;
            $display("FAIL diff_set_hit: got victim %0d expected 1", resp_victim);
        end
        req_set = 3'd4;
        step();
        req_valid = 1'b0;
        n_cmp++;
        if (resp_victim !== 2'd2) begin
            n_bad++;
            $display("FAIL diff_set_fill: got victim %0d expected 2", resp_victim);
        end
        step();
    endtask

    task automatic test_counters();
        do_reset();
        set_tags(9'h10, 9'h20, 9'h30, 9'h40, 4'b1111);
        req_valid = 1'b1; req_tag = 9'h10; req_set = 3'd0;
        for (int k = 0; k < 4; k++) step();
        n_cmp++;
        if (hit_count !== 2'd3) begin
            n_bad++;
            $display("FAIL hit_saturate: got %0d expected 3", hit_count);
        end
        stats_clear = 1'b1;
        step();
        stats_clear = 1'b0;
        n_cmp++;
        if (hit_count !== 2'd0) begin
            n_bad++;
            $display("FAIL clear_priority: got %0d expected 0", hit_count);
        end
        step();
        resp_ready = 1'b0;
        req_valid = 1'b0;
        step();
        rst_n = 1'b0;
        fill_valid = 1'b1; stats_clear = 1'b1;
        step();
        n_cmp++;
        if (resp_valid !== 1'b0 || resp_hit !== 1'b0 || resp_hit_vec !== 4'b0000 || hit_count !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_pending: got v=%b hit=%b vec=%b hits=%0d expected 0 0 0000 0",
                     resp_valid, resp_hit, resp_hit_vec, hit_count);
        end
        rst_n = 1'b1;
        idle_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_basic_hit();
        test_victim_sequence();
        test_invalid_and_multi();
        test_stall_and_stream();
        test_same_set();
        test_counters();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
